score_display_scanner: RTL and testbench

//  Scheduler for the single shared Seg7Decoder on the 4-digit display. Takes the binary score from

---
 rtl/score_display_scanner_if.sv | 21 ++
 rtl/score_display_scanner.sv | 127 ++++++++++++
 tb/tb_score_display_scanner.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/score_display_scanner_if.sv
// Score / 7-segment scan bus between the score source, the scanner and the shared Seg7Decoder.
interface score_display_scanner_if #(
  parameter int SCORE_WIDTH = 8
);
  logic [SCORE_WIDTH-1:0] SCORE_IN;
  logic                   SCORE_VALID;
  logic                   BUSY;
  logic [1:0]             STROBE_COUNT;
  logic [3:0]             SEG_SELECT_OUT;
  logic [3:0]             BIN_OUT;

  modport master (
    output SCORE_IN, SCORE_VALID,
    input  BUSY, STROBE_COUNT, SEG_SELECT_OUT, BIN_OUT
  );

  modport slave (
    input  SCORE_IN, SCORE_VALID,
    output BUSY, STROBE_COUNT, SEG_SELECT_OUT, BIN_OUT
  );
endinterface

// File: rtl/score_display_scanner.sv
// Sequential double-dabble BCD converter plus 4-digit time-multiplexed scan for one shared Seg7Decoder.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digit slots above slot 0.
module score_display_scanner #(
  parameter int SCORE_WIDTH = 8,
  parameter int REFRESH_DIV = 100000
) (
  input logic                    CLK,
  input logic                    RESET,
  score_display_scanner_if.slave bus
);
  localparam int SRW = 16 + SCORE_WIDTH;
  localparam int CW  = $clog2(SCORE_WIDTH + 1);
  localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SCORE_WIDTH);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t                 state, state_nxt;
  logic [SRW-1:0]         sreg, sreg_adj;
  logic [CW-1:0]          bit_cnt;
  logic                   pend_vld;
  logic [SCORE_WIDTH-1:0] pend_val;
  logic [3:0][3:0]        digits;
  logic [RW-1:0]          ref_cnt;
  logic [1:0]             slot;
  logic                   load_new, load_pend, commit, busy;
  logic [3:0]             blank;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.SCORE_VALID) state_nxt = CONVERT;
      CONVERT: if (bit_cnt == CW'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = (bus.SCORE_VALID || pend_vld) ? CONVERT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh strobe on the COMMIT cycle beats any older pending value.
  always_comb begin
    load_new  = 1'b0;
    load_pend = 1'b0;
    commit    = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    load_new = bus.SCORE_VALID;
      CONVERT: busy = 1'b1;
      COMMIT: begin
        busy      = 1'b1;
        commit    = 1'b1;
        load_new  = bus.SCORE_VALID;
        load_pend = !bus.SCORE_VALID && pend_vld;
      end
      default: ;
    endcase
  end

  always_comb begin
    sreg_adj = sreg;
    for (int n = 0; n < 4; n++)
      if (sreg[SCORE_WIDTH+4*n +: 4] >= 4'd5)
        sreg_adj[SCORE_WIDTH+4*n +: 4] = sreg[SCORE_WIDTH+4*n +: 4] + 4'd3;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      digits   <= '0;
    end else begin
      if (load_new) begin
        sreg    <= {16'b0, bus.SCORE_IN};
        bit_cnt <= CNT_INIT;
      end else if (load_pend) begin
        sreg    <= {16'b0, pend_val};
        bit_cnt <= CNT_INIT;
      end else if (state == CONVERT) begin
        sreg    <= sreg_adj << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
      // Digits only change here, as a whole, so no partial value is ever displayed.
      if (commit) begin
        digits   <= sreg[SRW-1 -: 16];
        pend_vld <= 1'b0;
      end else if (state == CONVERT && bus.SCORE_VALID) begin
        pend_vld <= 1'b1;
        pend_val <= bus.SCORE_IN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ref_cnt <= '0;
      slot    <= 2'd0;
    end else if (ref_cnt == REF_LAST) begin
      ref_cnt <= '0;
      slot    <= slot + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank[0] = 1'b0;
    blank[3] = (digits[3] == 4'd0);
    blank[2] = blank[3] && (digits[2] == 4'd0);
    blank[1] = blank[2] && (digits[1] == 4'd0);
  end
`else
  assign blank = 4'b0000;
`endif

  assign bus.BUSY           = busy;
  assign bus.STROBE_COUNT   = slot;
  assign bus.SEG_SELECT_OUT = blank[slot] ? 4'b1111 : ~(4'b0001 << slot);
  assign bus.BIN_OUT        = blank[slot] ? 4'h0 : digits[slot];
endmodule

// File: tb/tb_score_display_scanner.sv
// Directed bench for score_display_scanner: conversion latency, chaining, reset abort, scan and blanking.
module tb_score_display_scanner;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_display_scanner_if #(.SCORE_WIDTH(8)) bus0 ();
  score_display_scanner_if #(.SCORE_WIDTH(8)) bus1 ();

  score_display_scanner #(.SCORE_WIDTH(8), .REFRESH_DIV(4)) u_dut (
    .CLK(clk), .RESET(rst_n), .bus(bus0.slave));
  score_display_scanner #(.SCORE_WIDTH(8), .REFRESH_DIV(1)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int shown  = 0;

  // Edges since reset release; with REFRESH_DIV=4 the active slot is (cyc/4)%4.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic logic [3:0] exp_bin(input int v, input int s);
    int p = 1;
    for (int i = 0; i < s; i++) p *= 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0 && v < p) return 4'd0;
`endif
    return 4'((v / p) % 10);
  endfunction

  function automatic logic [3:0] exp_seg(input int v, input int s);
    int p = 1;
    logic [3:0] m;
    for (int i = 0; i < s; i++) p *= 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0 && v < p) return 4'b1111;
`endif
    m = 4'b0001 << s;
    return ~m;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    bus0.SCORE_IN = '0; bus0.SCORE_VALID = 1'b0;
    bus1.SCORE_IN = '0; bus1.SCORE_VALID = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus0.BUSY); end
    checks++; if (bus0.SEG_SELECT_OUT !== 4'b1110) begin errors++; $display("FAIL rst_seg got %b exp 1110", bus0.SEG_SELECT_OUT); end
    checks++; if (bus0.BIN_OUT !== 4'd0) begin errors++; $display("FAIL rst_bin got %0d exp 0", bus0.BIN_OUT); end
    checks++; if (bus0.STROBE_COUNT !== 2'd0) begin errors++; $display("FAIL rst_strobe got %0d exp 0", bus0.STROBE_COUNT); end
    rst_n = 1'b1;
    shown = 0;
  endtask

  task automatic test_convert;
    int slot, v;
    bus0.SCORE_IN = 8'd237; bus0.SCORE_VALID = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus0.SCORE_VALID = 1'b0;
      slot = (cyc / 4) % 4;
      v = (k < 9) ? shown : 237;
      checks++; if (bus0.BUSY !== (k < 9)) begin errors++; $display("FAIL t1_busy k=%0d got %b exp %b", k, bus0.BUSY, k < 9); end
      checks++; if (bus0.BIN_OUT !== exp_bin(v, slot)) begin errors++; $display("FAIL t1_bin k=%0d got %0d exp %0d", k, bus0.BIN_OUT, exp_bin(v, slot)); end
    end
    shown = 237;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      slot = (cyc / 4) % 4;
      checks++; if (bus0.STROBE_COUNT !== 2'(slot)) begin errors++; $display("FAIL t1_strobe k=%0d got %0d exp %0d", k, bus0.STROBE_COUNT, slot); end
      checks++; if (bus0.BIN_OUT !== exp_bin(237, slot)) begin errors++; $display("FAIL t1_scan_bin k=%0d got %0d exp %0d", k, bus0.BIN_OUT, exp_bin(237, slot)); end
      checks++; if (bus0.SEG_SELECT_OUT !== exp_seg(237, slot)) begin errors++; $display("FAIL t1_scan_seg k=%0d got %b exp %b", k, bus0.SEG_SELECT_OUT, exp_seg(237, slot)); end
    end
  endtask

  task automatic test_back_to_back;
    int slot, v;
    bus0.SCORE_IN = 8'd12; bus0.SCORE_VALID = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      slot = (cyc / 4) % 4;
      v = (k < 9) ? shown : (k < 18) ? 12 : 45;
      checks++; if (bus0.BUSY !== (k < 18)) begin errors++; $display("FAIL t2_busy k=%0d got %b exp %b", k, bus0.BUSY, k < 18); end
      checks++; if (bus0.BIN_OUT !== exp_bin(v, slot)) begin errors++; $display("FAIL t2_bin k=%0d got %0d exp %0d", k, bus0.BIN_OUT, exp_bin(v, slot)); end
      bus0.SCORE_VALID = (k == 1 || k == 3);
      bus0.SCORE_IN    = (k == 1) ? 8'd99 : 8'd45;
    end
    shown = 45;
  endtask

  task automatic test_commit_chain;
    int slot, v;
    bus0.SCORE_IN = 8'd12; bus0.SCORE_VALID = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      slot = (cyc / 4) % 4;
      v = (k < 9) ? shown : (k < 18) ? 12 : 200;
      checks++; if (bus0.BUSY !== (k < 18)) begin errors++; $display("FAIL t3_busy k=%0d got %b exp %b", k, bus0.BUSY, k < 18); end
      checks++; if (bus0.BIN_OUT !== exp_bin(v, slot)) begin errors++; $display("FAIL t3_bin k=%0d got %0d exp %0d", k, bus0.BIN_OUT, exp_bin(v, slot)); end
      bus0.SCORE_VALID = (k == 8);
      bus0.SCORE_IN    = 8'd200;
    end
    shown = 200;
  endtask

  task automatic test_reset_mid;
    int slot;
    bus0.SCORE_IN = 8'd255; bus0.SCORE_VALID = 1'b1;
    @(negedge clk);
    bus0.SCORE_VALID = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL t4_busy got %b exp 0", bus0.BUSY); end
    checks++; if (bus0.SEG_SELECT_OUT !== 4'b1110) begin errors++; $display("FAIL t4_seg got %b exp 1110", bus0.SEG_SELECT_OUT); end
    checks++; if (bus0.BIN_OUT !== 4'd0) begin errors++; $display("FAIL t4_bin got %0d exp 0", bus0.BIN_OUT); end
    checks++; if (bus0.STROBE_COUNT !== 2'd0) begin errors++; $display("FAIL t4_strobe got %0d exp 0", bus0.STROBE_COUNT); end
    @(negedge clk);
    rst_n = 1'b1;
    shown = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      slot = (cyc / 4) % 4;
      checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL t4_idle_busy k=%0d got %b exp 0", k, bus0.BUSY); end
      checks++; if (bus0.STROBE_COUNT !== 2'(slot)) begin errors++; $display("FAIL t4_scan k=%0d got %0d exp %0d", k, bus0.STROBE_COUNT, slot); end
      checks++; if (bus0.BIN_OUT !== 4'd0) begin errors++; $display("FAIL t4_zero k=%0d got %0d exp 0", k, bus0.BIN_OUT); end
    end
  endtask

  task automatic test_scan_wrap;
    int seq [5] = '{0, 1, 2, 3, 0};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    shown = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (bus1.STROBE_COUNT !== 2'(seq[i])) begin errors++; $display("FAIL t5_strobe i=%0d got %0d exp %0d", i, bus1.STROBE_COUNT, seq[i]); end
      checks++; if (bus1.SEG_SELECT_OUT !== exp_seg(0, seq[i])) begin errors++; $display("FAIL t5_seg i=%0d got %b exp %b", i, bus1.SEG_SELECT_OUT, exp_seg(0, seq[i])); end
    end
  endtask

  task automatic test_blank;
    int vals [3] = '{5, 0, 255};
    int slot;
    for (int j = 0; j < 3; j++) begin
      bus0.SCORE_IN = 8'(vals[j]); bus0.SCORE_VALID = 1'b1;
      @(negedge clk);
      bus0.SCORE_VALID = 1'b0;
      repeat (9) @(negedge clk);
      shown = vals[j];
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        slot = (cyc / 4) % 4;
        checks++; if (bus0.SEG_SELECT_OUT !== exp_seg(shown, slot)) begin errors++; $display("FAIL t6_seg v=%0d slot=%0d got %b exp %b", shown, slot, bus0.SEG_SELECT_OUT, exp_seg(shown, slot)); end
        checks++; if (bus0.BIN_OUT !== exp_bin(shown, slot)) begin errors++; $display("FAIL t6_bin v=%0d slot=%0d got %0d exp %0d", shown, slot, bus0.BIN_OUT, exp_bin(shown, slot)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_back_to_back();
    test_commit_chain();
    test_reset_mid();
    test_scan_wrap();
    test_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
